mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, selected by the R-type funct field. It is the parametrised successor of the single-cycle ALU path, which carries no multiply or divide. It sits beside the ALU in the execute stage: control raises `start` with funct and operands, then stalls on `busy` until `done`.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `funct`  in  6  operation: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / move source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `busy`  out  1  operation in flight; new starts ignored.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `div_zero`  out  1  last DIV/DIVU had `b`=0; held until the next accepted start.
- `hi`  out  WIDTH  HI register (MFHI source).
- `lo`  out  WIDTH  LO register (MFLO source).

## Operation
- States: IDLE, PREP, CALC, DONE.
- Reset (any time, including mid-operation) forces:
  - state IDLE, cycle counter 0;
  - `hi`=0, `lo`=0;
  - `busy`=0, `done`=0, `div_zero`=0.
- IDLE or DONE, `start`=1, MULT/MULTU/DIV/DIVU:
  - latch `a`, `b`, funct, and operand signs (signed ops only);
  - clear `div_zero`; go to PREP.
- PREP: form magnitudes (two's-complement negate of negative operands, signed ops only); load counter = WIDTH; go to CALC.
- CALC multiply: radix-2 shift-add of magnitudes into a 2·WIDTH accumulator, one bit per cycle.
- CALC divide: radix-2 restoring division on magnitudes, one quotient bit per cycle.
- CALC bookkeeping: counter decrements each cycle; on the cycle it reaches 1, apply the sign fix, write HI/LO, and go to DONE.
- Sign fix:
  - product: negated as 2·WIDTH if signs differ; HI:LO = product.
  - quotient: negated if signs differ; LO = quotient.
  - remainder: takes the dividend's sign; HI = remainder.
- Divide by zero, either signedness:
  - LO = all ones, HI = original `a`, `div_zero`=1;
  - still takes full latency.
- Signed overflow (DIV, MIN / −1): LO = MIN, HI = 0; falls out of magnitude arithmetic, no special case.
- MTHI / MTLO with `start` in IDLE or DONE:
  - HI (resp. LO) ← `a` at that edge; the other register is untouched;
  - no busy; `done` pulses the next cycle; `div_zero` cleared.
- DONE: `done`=1 for exactly one cycle, then IDLE, unless a new start is accepted in that cycle.
- `start` while `busy`=1: ignored entirely (no latch, no register change).
- `start` with any other funct: ignored, state unchanged.

## Timing
- All outputs registered.
- Cycle 0 = cycle in which `start` is sampled high and accepted.
- MUL/DIV:
  - `busy`=1 in cycles 1..WIDTH+1;
  - HI/LO update at the end of cycle WIDTH+1;
  - `done`=1 in cycle WIDTH+2 (34 for WIDTH=32).
- MTHI/MTLO: register visible in cycle 1; `done`=1 in cycle 1.
- Back-to-back: `start` in the DONE cycle is accepted, so a new PREP begins in the next cycle. The DONE cycle itself still shows the previous result and `done`=1.
- HI/LO never change while `busy`=1; MFHI/MFLO reads during busy return the old values.

## Structure
- Shared package `mdu_pkg`: funct localparams (MULT, MULTU, DIV, DIVU, MTHI, MTLO) and state encoding (IDLE, PREP, CALC, DONE).
- Package is shared with the main decoder, so stall logic decodes the same constants.
- One sub-module `cond_negate`: parametrised width, input `x`, enable `neg`, output `neg ? −x : x`.
- `cond_negate` is instantiated for operand magnitudes and for product/quotient/remainder fix-up.
- Datapath (accumulator, counter, shift logic) stays in `mul_div_unit`.

## Test plan
- MULT `a`=−3 (0xFFFFFFFD), `b`=7 → `done` in cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFEB; `busy` high cycles 1–33.
- MULTU `a`=`b`=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV `a`=−7, `b`=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); DIVU 7/0 → LO=0xFFFFFFFF, HI=7, `div_zero`=1, cleared by the next start.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Then `start` with MULT asserted mid-CALC → ignored, result unchanged.
- MTHI `a`=0x12345678 → HI=0x12345678 in cycle 1, LO unchanged, `done` in cycle 1. Back-to-back MULTU started in the DONE cycle → second `done` exactly 34 cycles later.
- `rst_n` low at cycle 10 of a DIV → `busy`, `done`, `div_zero`, HI, LO all 0 immediately. After release, a fresh MULTU 5×6 gives LO=30, HI=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared constants for the multiply/divide unit: R-type funct codes for the
// HI/LO instructions and the unit's state encoding. The main decoder imports
// the same package so its stall logic decodes identical constants.
// Also carries small decode helpers used by the unit.
// -----------------------------------------------------------------------------
package mdu_pkg;

    // R-type funct codes handled by the multiply/divide unit
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    // Unit state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PREP = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // True for the four multi-cycle arithmetic operations
    function automatic logic is_muldiv_op(input logic [5:0] f);
        logic r;
        case (f)
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the single-cycle HI/LO moves
    function automatic logic is_move_op(input logic [5:0] f);
        logic r;
        case (f)
            FUNCT_MTHI, FUNCT_MTLO: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // True for DIV/DIVU
    function automatic logic is_div_op(input logic [5:0] f);
        logic r;
        case (f)
            FUNCT_DIV, FUNCT_DIVU: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the signed variants MULT/DIV
    function automatic logic is_signed_op(input logic [5:0] f);
        logic r;
        case (f)
            FUNCT_MULT, FUNCT_DIV: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cond_negate.sv
// -----------------------------------------------------------------------------
// cond_negate
// Conditional two's-complement negation: y = neg ? -x : x.
// Used for operand magnitudes and for the product/quotient/remainder sign fix.
// Ports:
//   x    in  WIDTH  value
//   neg  in  1      negate enable
//   y    out WIDTH  result
// -----------------------------------------------------------------------------
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    // Negate or pass through
    always_comb begin
        if (neg) begin
            y = (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            y = x;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle integer multiply/divide unit with architectural HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU (radix-2, one bit per cycle on magnitudes)
// and the single-cycle moves MTHI/MTLO.
// Ports:
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   start     in  1      request, accepted only while not busy
//   funct     in  6      operation select (R-type funct)
//   a         in  WIDTH  rs operand (dividend / multiplicand / move source)
//   b         in  WIDTH  rt operand (divisor / multiplier)
//   busy      out 1      operation in flight
//   done      out 1      one-cycle completion pulse
//   div_zero  out 1      last DIV/DIVU had b == 0 (held until next start)
//   hi        out WIDTH  HI register
//   lo        out WIDTH  LO register
// Latency for MUL/DIV: busy in cycles 1..WIDTH+1, done in cycle WIDTH+2.
// -----------------------------------------------------------------------------
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Control / architectural registers
    logic [1:0]         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    // Latched operation
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               is_div_r;
    logic               sign_a_r;
    logic               sign_b_r;

    // Datapath: acc_r upper half is the partial product / partial remainder,
    // lower half the multiplier / dividend being shifted out (quotient shifted in).
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opnd_r;

    // Combinational datapath signals
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic               div_zero_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;
    logic               sign_diff_s;
    logic               accept_muldiv_s;
    logic               accept_move_s;
    logic               last_step_s;

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

    assign sign_diff_s = sign_a_r ^ sign_b_r;
    assign div_zero_s  = is_div_r & (b_r == {WIDTH{1'b0}});
    assign last_step_s = (cnt_r == CNT_W'(1));

    // Operand magnitudes (sign bits are only latched for signed ops)
    cond_negate #(.WIDTH(WIDTH)) u_mag_a (.x(a_r), .neg(sign_a_r), .y(mag_a_s));
    cond_negate #(.WIDTH(WIDTH)) u_mag_b (.x(b_r), .neg(sign_b_r), .y(mag_b_s));

    // Result sign fix-up applied to the final step's value
    cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (.x(step_s), .neg(sign_diff_s), .y(prod_fix_s));
    cond_negate #(.WIDTH(WIDTH)) u_fix_quo (.x(step_s[WIDTH-1:0]), .neg(sign_diff_s), .y(quo_fix_s));
    cond_negate #(.WIDTH(WIDTH)) u_fix_rem (.x(step_s[2*WIDTH-1:WIDTH]), .neg(sign_a_r), .y(rem_fix_s));

    // Start decode: moves and arithmetic are only taken in IDLE or DONE
    always_comb begin
        accept_muldiv_s = 1'b0;
        accept_move_s   = 1'b0;
        if (start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
            accept_muldiv_s = is_muldiv_op(funct);
            accept_move_s   = is_move_op(funct);
        end else begin
            accept_muldiv_s = 1'b0;
            accept_move_s   = 1'b0;
        end
    end

    // One shift-add multiply step: conditionally add, then shift right with carry
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end

    // One restoring-division step: shift in next dividend bit, trial subtract
    always_comb begin
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, opnd_r};
        if (div_trial_s[WIDTH]) begin
            // Trial went negative: restore, quotient bit 0
            div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end else begin
            div_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end
    end

    // Select the active step and form the HI/LO result of the final cycle
    always_comb begin
        step_s   = mul_next_s;
        res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_fix_s[WIDTH-1:0];
        if (!is_div_r) begin
            step_s   = mul_next_s;
            res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_fix_s[WIDTH-1:0];
        end else if (div_zero_s) begin
            // Divide by zero still runs full latency; result is overridden here
            step_s   = div_next_s;
            res_hi_s = a_r;
            res_lo_s = {WIDTH{1'b1}};
        end else begin
            step_s   = div_next_s;
            res_hi_s = rem_fix_s;
            res_lo_s = quo_fix_s;
        end
    end

    // State machine, datapath and architectural HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            acc_r      <= {(2*WIDTH){1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_muldiv_s) begin
                        state_r    <= ST_PREP;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        div_zero_r <= 1'b0;
                        a_r        <= a;
                        b_r        <= b;
                        is_div_r   <= is_div_op(funct);
                        sign_a_r   <= is_signed_op(funct) & a[WIDTH-1];
                        sign_b_r   <= is_signed_op(funct) & b[WIDTH-1];
                    end else if (accept_move_s) begin
                        // Moves complete at this edge; DONE gives the done pulse
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                        div_zero_r <= 1'b0;
                        if (funct == FUNCT_MTHI) begin
                            hi_r <= a;
                        end else begin
                            lo_r <= a;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                    end
                end
                ST_PREP: begin
                    state_r <= ST_CALC;
                    cnt_r   <= CNT_W'(WIDTH);
                    if (is_div_r) begin
                        acc_r  <= {{WIDTH{1'b0}}, mag_a_s};
                        opnd_r <= mag_b_s;
                    end else begin
                        acc_r  <= {{WIDTH{1'b0}}, mag_b_s};
                        opnd_r <= mag_a_s;
                    end
                end
                ST_CALC: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (last_step_s) begin
                        state_r    <= ST_DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        hi_r       <= res_hi_s;
                        lo_r       <= res_lo_s;
                        div_zero_r <= div_zero_s;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Self-checking bench for mul_div_unit (WIDTH=32). Expected HI/LO values come
// from plain 64-bit arithmetic on the operands; cycle expectations come from
// the documented latency (busy cycles 1..33, done in cycle 34).
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam int WIDTH = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int check_count = 0;
    int fail_count  = 0;

    // Architectural state the bench expects
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;

    logic [5:0] op_table [6];

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .funct    (funct),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result of one operation computed with plain arithmetic
    function automatic void model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] old_hi, input logic [31:0] old_lo,
                                  output logic [31:0] new_hi, output logic [31:0] new_lo,
                                  output logic new_dz);
        longint sx;
        longint sy;
        longint sq;
        longint sr;
        logic [63:0] p;
        new_hi = old_hi;
        new_lo = old_lo;
        new_dz = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (f == F_MULT) begin
            p = 64'(sx * sy);
            new_hi = p[63:32];
            new_lo = p[31:0];
        end else if (f == F_MULTU) begin
            p = {32'h0, x} * {32'h0, y};
            new_hi = p[63:32];
            new_lo = p[31:0];
        end else if ((f == F_DIV || f == F_DIVU) && y == 32'h0) begin
            new_hi = x;
            new_lo = 32'hFFFF_FFFF;
            new_dz = 1'b1;
        end else if (f == F_DIV) begin
            sq = sx / sy;
            sr = sx % sy;
            new_lo = sq[31:0];
            new_hi = sr[31:0];
        end else if (f == F_DIVU) begin
            new_lo = x / y;
            new_hi = x % y;
        end else if (f == F_MTHI) begin
            new_hi = x;
        end else if (f == F_MTLO) begin
            new_lo = x;
        end
    endfunction

    // Present a request during the current cycle; it is sampled at the next edge
    task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        funct = f;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct = 6'b000000;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Follow an accepted MUL/DIV from cycle 1 to its done cycle; optionally
    // poke a start mid-flight and optionally chain a new op in the DONE cycle
    task automatic wait_muldiv(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                               input int poke, input string name, input bit chain,
                               input logic [5:0] nf, input logic [31:0] nx, input logic [31:0] ny);
        logic [31:0] nh;
        logic [31:0] nl;
        logic        nz;
        bit          bad;
        int          bad_cyc;
        logic [3:0]  bad_flags;
        logic [31:0] bad_hi;
        logic [31:0] bad_lo;
        model(f, x, y, exp_hi, exp_lo, nh, nl, nz);
        bad = 1'b0;
        bad_cyc = 0;
        bad_flags = 4'h0;
        bad_hi = 32'h0;
        bad_lo = 32'h0;
        for (int cyc = 1; cyc <= WIDTH + 1; cyc++) begin
            @(negedge clk);
            if (!bad && (busy !== 1'b1 || done !== 1'b0 || div_zero !== 1'b0 ||
                         hi !== exp_hi || lo !== exp_lo)) begin
                bad = 1'b1;
                bad_cyc = cyc;
                bad_flags = {1'b0, busy, done, div_zero};
                bad_hi = hi;
                bad_lo = lo;
            end
            if (cyc == poke) begin
                start = 1'b1;
                funct = F_MULT;
                a     = $urandom;
                b     = $urandom;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        check_count++;
        if (bad) begin
            fail_count++;
            $display("FAIL %s in_flight cycle=%0d busy/done/dz=%b hi=%h lo=%h required busy/done/dz=100 hi=%h lo=%h",
                     name, bad_cyc, bad_flags[2:0], bad_hi, bad_lo, exp_hi, exp_lo);
        end
        // Cycle WIDTH+2: done pulse with the new result
        @(negedge clk);
        check_count++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fail_count++;
            $display("FAIL %s done_cycle done=%b busy=%b required done=1 busy=0", name, done, busy);
        end
        check_count++;
        if (hi !== nh) begin
            fail_count++;
            $display("FAIL %s hi got=%h required=%h", name, hi, nh);
        end
        check_count++;
        if (lo !== nl) begin
            fail_count++;
            $display("FAIL %s lo got=%h required=%h", name, lo, nl);
        end
        check_count++;
        if (div_zero !== nz) begin
            fail_count++;
            $display("FAIL %s div_zero got=%b required=%b", name, div_zero, nz);
        end
        exp_hi = nh;
        exp_lo = nl;
        exp_dz = nz;
        if (chain) begin
            issue(nf, nx, ny);
        end else begin
            @(negedge clk);
            check_count++;
            if (done !== 1'b0 || busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo || div_zero !== exp_dz) begin
                fail_count++;
                $display("FAIL %s after_done done=%b busy=%b dz=%b hi=%h lo=%h required done=0 busy=0 dz=%b hi=%h lo=%h",
                         name, done, busy, div_zero, hi, lo, exp_dz, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic run_muldiv(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                              input int poke, input string name);
        @(negedge clk);
        issue(f, x, y);
        wait_muldiv(f, x, y, poke, name, 1'b0, 6'h0, 32'h0, 32'h0);
    endtask

    // MTHI/MTLO: register visible and done high in cycle 1, no busy
    task automatic run_move(input logic [5:0] f, input logic [31:0] x, input string name,
                            input bit chain, input logic [5:0] nf, input logic [31:0] nx,
                            input logic [31:0] ny);
        logic [31:0] nh;
        logic [31:0] nl;
        logic        nz;
        model(f, x, 32'h0, exp_hi, exp_lo, nh, nl, nz);
        issue(f, x, $urandom);
        @(negedge clk);
        check_count++;
        if (done !== 1'b1 || busy !== 1'b0 || div_zero !== 1'b0) begin
            fail_count++;
            $display("FAIL %s cycle1 done=%b busy=%b dz=%b required done=1 busy=0 dz=0", name, done, busy, div_zero);
        end
        check_count++;
        if (hi !== nh || lo !== nl) begin
            fail_count++;
            $display("FAIL %s regs hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, nh, nl);
        end
        exp_hi = nh;
        exp_lo = nl;
        exp_dz = 1'b0;
        if (chain) begin
            issue(nf, nx, ny);
        end else begin
            @(negedge clk);
            check_count++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fail_count++;
                $display("FAIL %s cycle2 done=%b busy=%b required done=0 busy=0", name, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        funct = 6'h0;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(negedge clk);
        check_count++;
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            fail_count++;
            $display("FAIL reset_flags busy=%b done=%b dz=%b required 000", busy, done, div_zero);
        end
        check_count++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            fail_count++;
            $display("FAIL reset_regs hi=%h lo=%h required 0", hi, lo);
        end
        rst_n  = 1'b1;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        exp_dz = 1'b0;
    endtask

    task automatic test_directed();
        run_muldiv(F_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 0, "mult_neg3x7");
        run_muldiv(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
        run_muldiv(F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, "div_neg7by2");
        run_muldiv(F_DIVU,  32'h0000_0007, 32'h0000_0000, 0, "divu_by_zero");
    endtask

    // div_zero holds through idle cycles and an ignored funct; next start clears it
    task automatic test_div_zero_hold();
        repeat (3) @(negedge clk);
        check_count++;
        if (div_zero !== 1'b1) begin
            fail_count++;
            $display("FAIL dz_hold div_zero=%b required 1", div_zero);
        end
        issue(6'b100000, $urandom, $urandom);
        @(negedge clk);
        check_count++;
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin
            fail_count++;
            $display("FAIL bad_funct busy=%b done=%b dz=%b hi=%h lo=%h required 0 0 1 hi=%h lo=%h",
                     busy, done, div_zero, hi, lo, exp_hi, exp_lo);
        end
        run_muldiv(F_DIV, 32'h0000_0064, 32'h0000_0007, 0, "div_after_dz");
    endtask

    task automatic test_overflow_ignore();
        run_muldiv(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_min_by_m1");
        run_muldiv(F_DIV, 32'h8000_0000, 32'h0000_0000, 20, "div_min_by_zero");
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1;
        logic [31:0] y1;
        logic [31:0] x2;
        logic [31:0] y2;
        x1 = $urandom;
        y1 = $urandom;
        x2 = $urandom;
        y2 = $urandom;
        @(negedge clk);
        run_move(F_MTHI, 32'h1234_5678, "mthi", 1'b1, F_MULTU, x1, y1);
        wait_muldiv(F_MULTU, x1, y1, 0, "b2b_multu1", 1'b1, F_MULT, x2, y2);
        wait_muldiv(F_MULT, x2, y2, 0, "b2b_mult2", 1'b0, 6'h0, 32'h0, 32'h0);
        @(negedge clk);
        run_move(F_MTLO, 32'hCAFE_F00D, "mtlo", 1'b0, 6'h0, 32'h0, 32'h0);
    endtask

    task automatic test_random();
        logic [5:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        int          poke;
        for (int i = 0; i < 16; i++) begin
            f = op_table[$urandom_range(0, 5)];
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 4))
                0: y = 32'h0;
                1: y = 32'($urandom_range(1, 15));
                2: y = 32'hFFFF_FFFF;
                3: x = 32'h8000_0000;
                default: ;
            endcase
            poke = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, WIDTH + 1);
            if (f == F_MTHI || f == F_MTLO) begin
                @(negedge clk);
                run_move(f, x, "rand_move", 1'b0, 6'h0, 32'h0, 32'h0);
            end else begin
                run_muldiv(f, x, y, poke, "rand_muldiv");
            end
        end
    endtask

    // Reset asserted in cycle 10 of a DIV clears everything immediately
    task automatic test_reset_mid_op();
        run_muldiv(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "pre_reset");
        @(negedge clk);
        issue(F_DIV, 32'h7654_3210, 32'h0000_0013);
        repeat (9) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_count++;
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            fail_count++;
            $display("FAIL midreset_flags busy=%b done=%b dz=%b required 000", busy, done, div_zero);
        end
        check_count++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            fail_count++;
            $display("FAIL midreset_regs hi=%h lo=%h required 0", hi, lo);
        end
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        exp_dz = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_muldiv(F_MULTU, 32'd5, 32'd6, 0, "multu_5x6");
        check_count++;
        if (lo !== 32'd30 || hi !== 32'd0) begin
            fail_count++;
            $display("FAIL multu_5x6_direct hi=%h lo=%h required hi=0 lo=1e", hi, lo);
        end
    endtask

    initial begin
        op_table[0] = F_MULT;
        op_table[1] = F_MULTU;
        op_table[2] = F_DIV;
        op_table[3] = F_DIVU;
        op_table[4] = F_MTHI;
        op_table[5] = F_MTLO;
        test_reset();
        test_directed();
        test_div_zero_hold();
        test_overflow_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
